// File: rtl/aligned_ram_pkg.sv
// Shared constants, FSM state type and address helpers for the aligned word RAM.
package aligned_ram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {IDLE, BURST} state_e;

  // Word aligned and inside the array; the full 30-bit word index is compared.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[ADDR_W-1:2]} < depth);
  endfunction

  function automatic logic [ADDR_W-3:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/aligned_ram_mem.sv
// DEPTH x 32 storage: synchronous write port, registered read port (read-before-write).
module aligned_ram_mem
  import aligned_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/aligned_ram_reader.sv
// Aligned word RAM with checked write port and burst read port.
// Define ALIGNED_RAM_TRACE_EN to print a simulation trace of writes, beats and rejects.
module aligned_ram_reader
  import aligned_ram_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_error,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [$clog2(MAX_BURST)-1:0] rd_len,
  output logic                         rd_ready,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_last,
  output logic                         rd_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = $clog2(MAX_BURST);

  state_e             state;
  logic [LEN_W-1:0]   cnt;
  logic [IDX_W-1:0]   nxt_idx;
  logic               wr_legal;
  logic               rd_legal;
  logic               rd_accept;
  logic               mem_wr_en;
  logic [IDX_W-1:0]   mem_wr_idx;
  logic               mem_rd_en;
  logic [IDX_W-1:0]   mem_rd_idx;

  assign rd_ready = (state == IDLE);

  always_comb begin
    wr_legal   = addr_legal(wr_addr, DEPTH);
    rd_legal   = addr_legal(rd_addr, DEPTH);
    rd_accept  = rd_req && rd_ready;
    mem_wr_en  = wr_en && wr_legal;
    mem_wr_idx = IDX_W'(word_idx(wr_addr));
    mem_rd_en  = 1'b0;
    mem_rd_idx = nxt_idx;
    if (state == BURST) begin
      mem_rd_en = 1'b1;
    end else if (rd_accept && rd_legal) begin
      mem_rd_en  = 1'b1;
      mem_rd_idx = IDX_W'(word_idx(rd_addr));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      nxt_idx  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_error <= 1'b0;
      wr_error <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_error <= !wr_legal;
      end
      unique case (state)
        IDLE: begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
          rd_error <= 1'b0;
          if (rd_accept) begin
            if (rd_legal) begin
              rd_valid <= 1'b1;
              if (rd_len == '0) begin
                rd_last <= 1'b1;
              end else begin
                cnt     <= rd_len;
                nxt_idx <= mem_rd_idx + IDX_W'(1);
                state   <= BURST;
              end
            end else begin
              rd_error <= 1'b1;
            end
          end
        end
        BURST: begin
          rd_valid <= 1'b1;
          rd_error <= 1'b0;
          // Index wraps modulo DEPTH through natural overflow.
          nxt_idx  <= nxt_idx + IDX_W'(1);
          cnt      <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            rd_last <= 1'b1;
            state   <= IDLE;
          end else begin
            rd_last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  aligned_ram_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_idx  (mem_wr_idx),
    .wr_data (wr_data),
    .rd_en   (mem_rd_en),
    .rd_idx  (mem_rd_idx),
    .rd_data (rd_data)
  );

`ifdef ALIGNED_RAM_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        $display("%0t aligned_ram write addr=%h data=%h %s", $time, wr_addr, wr_data,
                 wr_legal ? "ok" : "rejected (misaligned/out-of-range)");
      end
      if (rd_valid) begin
        $display("%0t aligned_ram beat data=%h last=%0b", $time, rd_data, rd_last);
      end
      if (rd_accept && !rd_legal) begin
        $display("%0t aligned_ram read rejected addr=%h", $time, rd_addr);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_aligned_ram_reader.sv
// Scoreboard bench for aligned_ram_reader: directed stimulus, decoupled output monitor.
module tb_aligned_ram_reader;

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_error;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [3:0]  rd_len;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_error;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   valid_run = 0;
  int   max_run   = 0;

  aligned_ram_reader #(
    .DEPTH     (256),
    .MAX_BURST (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_error (wr_error),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_error (rd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every beat or error pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      valid_run++;
      if (valid_run > max_run) max_run = valid_run;
    end else begin
      valid_run = 0;
    end
    if (rd_valid || rd_error) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output valid=%0b err=%0b data=%h at %0t", rd_valid, rd_error,
                 rd_data, $time);
      end else begin
        e = exp_q.pop_front();
        if ({rd_error, rd_valid} !== {e.err, !e.err} ||
            (!e.err && (rd_data !== e.data || rd_last !== e.last))) begin
          failures++;
          $display("FAIL beat got err=%0b valid=%0b data=%h last=%0b want err=%0b data=%h last=%0b",
                   rd_error, rd_valid, rd_data, rd_last, e.err, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic last);
    exp_t e;
    e.err = 1'b0; e.data = d; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.data = '0; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Waits (bounded) for rd_ready, then issues one request; reports cycles spent waiting.
  task automatic rd(input logic [31:0] a, input logic [3:0] len, output int waited);
    waited = 0;
    while (!rd_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!rd_ready) begin
      checks++;
      failures++;
      $display("FAIL rd_ready_timeout got=0 want=1");
    end
    rd_req = 1'b1; rd_addr = a; rd_len = len;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int w;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    drain(2);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_last", {31'd0, rd_last}, 32'd0);
    chk("reset_rd_error", {31'd0, rd_error}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_wr_error", {31'd0, wr_error}, 32'd0);
    chk("reset_rd_ready", {31'd0, rd_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Single-beat read, one-cycle latency
    wr(32'h10, 32'hDEADBEEF);
    chk("wr_error_legal", {31'd0, wr_error}, 32'd0);
    push_beat(32'hDEADBEEF, 1'b1);
    rd(32'h10, 4'd0, w);
    chk("latency_valid", {31'd0, rd_valid}, 32'd1);
    chk("latency_data", rd_data, 32'hDEADBEEF);
    tick();
    chk("single_done_valid", {31'd0, rd_valid}, 32'd0);

    // 4-beat burst followed by a gapless back-to-back burst
    for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(i + 1));
    drain(2);
    max_run = 0;
    for (int i = 0; i < 4; i++) push_beat(32'(i + 1), i == 3);
    rd(32'h0, 4'd3, w);
    for (int i = 0; i < 4; i++) push_beat(32'(i + 1), i == 3);
    rd(32'h0, 4'd3, w);
    chk("ready_low_cycles", 32'(w), 32'd3);
    drain(6);
    chk("gapless_run", 32'(max_run), 32'd8);

    // Wrap from the last word to word 0
    wr(32'h3FC, 32'hCAFE00FF);
    push_beat(32'hCAFE00FF, 1'b0);
    push_beat(32'h1, 1'b1);
    rd(32'h3FC, 4'd1, w);
    drain(4);

    // Rejected reads and writes
    push_err();
    rd(32'h6, 4'd0, w);
    push_err();
    rd(32'h400, 4'd2, w);
    drain(3);
    wr(32'h2, 32'h77);
    chk("wr_error_misaligned", {31'd0, wr_error}, 32'd1);
    tick();
    chk("wr_error_hold", {31'd0, wr_error}, 32'd1);
    wr(32'h404, 32'h88);
    chk("wr_error_range", {31'd0, wr_error}, 32'd1);
    push_beat(32'h1, 1'b1);
    rd(32'h0, 4'd0, w);
    drain(2);
    wr(32'h14, 32'h99);
    chk("wr_error_cleared", {31'd0, wr_error}, 32'd0);

    // Same-edge write and read of one word returns old data
    wr(32'h20, 32'hAA);
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'h55;
    push_beat(32'hAA, 1'b1);
    rd(32'h20, 4'd0, w);
    wr_en = 1'b0;
    push_beat(32'h55, 1'b1);
    rd(32'h20, 4'd0, w);
    drain(2);

    // Reset aborts a 16-beat burst; memory survives
    for (int i = 0; i < 16; i++) wr(32'(i * 4), 32'h100 + 32'(i));
    for (int i = 0; i < 5; i++) push_beat(32'h100 + 32'(i), 1'b0);
    rd(32'h0, 4'd15, w);
    drain(4);
    rst = 1'b1;
    tick();
    chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("abort_rd_ready", {31'd0, rd_ready}, 32'd1);
    rst = 1'b0;
    drain(2);
    chk("abort_stays_idle", {31'd0, rd_valid}, 32'd0);
    push_beat(32'h105, 1'b1);
    rd(32'h14, 4'd0, w);
    drain(3);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
